// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: FSM encoding,
// default NOP instruction and little-endian byte-lane numbering.
package inst_rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    localparam int unsigned BYTE_W = 8;

    // Lane 0 carries bits [7:0], i.e. the first byte received.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words; word_valid
// pulses in the same cycle that the fourth byte is accepted.
module byte_packer
    import inst_rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [31:0]       word,
    output logic              word_valid
);

    logic [1:0]          lane_q;
    logic [3*BYTE_W-1:0] low_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= LANE_0;
            low_q  <= '0;
        end else if (clear) begin
            lane_q <= LANE_0;
        end else if (accept) begin
            case (lane_q)
                LANE_0:  low_q[BYTE_W-1:0]          <= byte_in;
                LANE_1:  low_q[2*BYTE_W-1:BYTE_W]   <= byte_in;
                LANE_2:  low_q[3*BYTE_W-1:2*BYTE_W] <= byte_in;
                default: ;
            endcase
            lane_q <= lane_q + 2'd1;
        end
    end

    // The top lane is taken straight from the input so the word is complete
    // on the accepting edge without an extra register stage.
    assign word       = {byte_in, low_q};
    assign word_valid = accept && (lane_q == LANE_3);

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core fetch port plus the boot loader that fills
// it from a byte-serial stream (length header, then words) and releases the core.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              load_valid_i,
    input  logic [7:0]        load_data_i,
    output logic              load_ready_o,
    input  logic              load_start_i,
    output logic              cpu_rst_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [31:0] DEPTH_W = 32'(1) << ADDR_W;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              accept, word_valid, clear, mem_we;
    logic [31:0]       word;
    logic [31:0]       mem [DEPTH];
    logic              unused_addr_lsb;

    // Handshake: a byte transfers on any rising edge where load_valid_i and
    // load_ready_o are both high; the sender holds data until then, and
    // load_ready_o depends only on state so it never combinationally
    // depends on load_valid_i.
    assign accept = load_valid_i && load_ready_o;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .accept     (accept),
        .byte_in    (load_data_i),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        len_d     = len_q;
        clear     = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d = ST_RUN;
                    end else if (word > DEPTH_W) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                        len_d   = word[ADDR_W:0];
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    if (count_d == len_q) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start_i) begin
                    state_d   = ST_HDR;
                    clear     = 1'b1;
                    wr_addr_d = '0;
                    count_d   = '0;
                end
            end
            ST_ERR: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HDR;
            wr_addr_q <= '0;
            count_q   <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            len_q     <= len_d;
        end
    end

    // The array is deliberately outside reset so a reload or reset keeps
    // any words beyond the newly loaded length.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_q] <= word;
    end

    assign load_ready_o = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign cpu_rst_o    = (state_q != ST_RUN);
    assign load_done_o  = (state_q == ST_RUN);
    assign load_err_o   = (state_q == ST_ERR);
    assign word_count_o = count_q;

    assign unused_addr_lsb = ^rom_addr_i[1:0];

    always_comb begin
        rom_data_o = '0;
        if (rom_ce_i) begin
            if (rom_addr_i[31:ADDR_W+2] != '0) rom_data_o = NOP_WORD;
            else                               rom_data_o = mem[rom_addr_i[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed boot/reload/error
// sequences, a fetch vector table and randomized loads against a stream model.
module tb_inst_rom_loader;
    import inst_rom_loader_pkg::*;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rom_ce_i = 1'b0;
    logic [31:0]       rom_addr_i = '0;
    logic [31:0]       rom_data_o;
    logic              load_valid_i = 1'b0;
    logic [7:0]        load_data_i = '0;
    logic              load_ready_o;
    logic              load_start_i = 1'b0;
    logic              cpu_rst_o;
    logic              load_done_o;
    logic              load_err_o;
    logic [ADDR_W:0]   word_count_o;

    inst_rom_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce_i),
        .rom_addr_i   (rom_addr_i),
        .rom_data_o   (rom_data_o),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_start_i (load_start_i),
        .cpu_rst_o    (cpu_rst_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .word_count_o (word_count_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Byte stream semantics: a 4-byte length header, then that many words;
    // an empty load or completed load means the core runs.
    logic [31:0] m_mem [DEPTH];
    bit          m_run, m_err, m_have_len;
    int unsigned m_len, m_written;
    logic [7:0]  byte_q[$];

    task automatic model_reset();
        m_run = 0; m_err = 0; m_have_len = 0; m_len = 0; m_written = 0;
        byte_q.delete();
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d, input bit s);
        logic [31:0] w;
        if (m_err) return;
        if (m_run) begin
            if (s) begin
                m_run = 0; m_have_len = 0; m_written = 0;
                byte_q.delete();
            end
            return;
        end
        if (!v) return;
        byte_q.push_back(d);
        if (byte_q.size() < 4) return;
        w = 32'(byte_q[0]) | (32'(byte_q[1]) << 8) | (32'(byte_q[2]) << 16) | (32'(byte_q[3]) << 24);
        byte_q.delete();
        if (!m_have_len) begin
            if (w == 0)              m_run = 1;
            else if (w > 32'(DEPTH)) m_err = 1;
            else begin m_have_len = 1; m_len = w; end
        end else begin
            m_mem[m_written] = w;
            m_written++;
            if (m_written == m_len) begin m_run = 1; m_have_len = 0; end
        end
    endtask

    task automatic check_outputs();
        chk("cpu_rst",    32'(cpu_rst_o),    32'(!m_run));
        chk("load_done",  32'(load_done_o),  32'(m_run));
        chk("load_err",   32'(load_err_o),   32'(m_err));
        chk("load_ready", 32'(load_ready_o), 32'(!m_run && !m_err));
        chk("word_count", 32'(word_count_o), m_written);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit v, input logic [7:0] d, input bit s);
        load_valid_i = v; load_data_i = d; load_start_i = s;
        @(posedge clk);
        model_cycle(v, d, s);
        #1;
        load_valid_i = 1'b0; load_start_i = 1'b0;
        check_outputs();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cycle(1'b1, w[8*i +: 8], 1'b0);
    endtask

    task automatic send_word_gappy(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) == 0)
                cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            cycle(1'b1, w[8*i +: 8], 1'b0);
        end
    endtask

    task automatic fetch(input bit ce, input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        rom_ce_i = ce; rom_addr_i = a;
        #1;
        chk(name, rom_data_o, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0; load_valid_i = 1'b0; load_start_i = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- fetch vector table ----------------
    typedef struct {
        bit          ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fetch_vec_t;

    fetch_vec_t fv[8];

    // ---------------- test ----------------
    initial begin
        int unsigned n, idx, a;
        logic [31:0] w;

        do_reset();
        chk("reset_cpu_rst",    32'(cpu_rst_o),    32'd1);
        chk("reset_ready",      32'(load_ready_o), 32'd1);
        chk("reset_done",       32'(load_done_o),  32'd0);
        chk("reset_err",        32'(load_err_o),   32'd0);
        chk("reset_word_count", 32'(word_count_o), 32'd0);

        // Zero-length load
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
        chk("zero_len_cpu_rst_before", 32'(cpu_rst_o), 32'd1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("zero_len_cpu_rst",  32'(cpu_rst_o),    32'd0);
        chk("zero_len_done",     32'(load_done_o),  32'd1);
        chk("zero_len_count",    32'(word_count_o), 32'd0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);

        // Basic load
        cycle(1'b0, 8'h00, 1'b1);
        chk("reload_cpu_rst", 32'(cpu_rst_o),    32'd1);
        chk("reload_ready",   32'(load_ready_o), 32'd1);
        chk("reload_count",   32'(word_count_o), 32'd0);
        send_word(32'd2);
        send_word(32'h0010_0093);
        fetch(1'b1, 32'h0, 32'h0010_0093, "basic_word0_next_cycle");
        chk("basic_cpu_rst_mid", 32'(cpu_rst_o), 32'd1);
        send_word(32'h0020_0113);
        fetch(1'b1, 32'h4, 32'h0020_0113, "basic_word1_next_cycle");
        chk("basic_count",   32'(word_count_o), 32'd2);
        chk("basic_cpu_rst", 32'(cpu_rst_o),    32'd0);

        fv[0] = '{1'b1, 32'h0000_0000, 32'h0010_0093};
        fv[1] = '{1'b1, 32'h0000_0004, 32'h0020_0113};
        fv[2] = '{1'b1, 32'h0000_0006, 32'h0020_0113};
        fv[3] = '{1'b1, 32'h0000_0003, 32'h0010_0093};
        fv[4] = '{1'b1, 32'h0000_1000, NOP};
        fv[5] = '{1'b1, 32'hFFFF_FFFC, NOP};
        fv[6] = '{1'b0, 32'h0000_0004, 32'h0};
        fv[7] = '{1'b0, 32'h0000_1000, 32'h0};
        for (int i = 0; i < 8; i++)
            fetch(fv[i].ce, fv[i].addr, fv[i].exp, $sformatf("fetch_vec%0d", i));

        // Reload of a single word leaves word 1 untouched
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        fetch(1'b1, 32'h0, 32'hDEAD_BEEF, "reload_word0");
        fetch(1'b1, 32'h4, 32'h0020_0113, "reload_word1_kept");

        // Randomized loads with gaps and stray start pulses
        for (int it = 0; it < 6; it++) begin
            cycle(1'b0, 8'h00, 1'b1);
            n = $urandom_range(1, 8);
            send_word_gappy(n);
            for (int k = 0; k < int'(n); k++) send_word_gappy($urandom);
            for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom), 1'b0);
            for (int k = 0; k < 6; k++) begin
                idx = $urandom_range(0, n - 1);
                a   = idx * 4 + $urandom_range(0, 3);
                exp_q.push_back(m_mem[idx]);
                fetch(1'b1, a, exp_q.pop_front(), "rand_fetch");
            end
            a = ($urandom_range(1, 20'hF_FFFF) << 12) | $urandom_range(0, 4095);
            fetch(1'b1, a, NOP, "rand_fetch_oob");
            fetch(1'b0, $urandom, 32'h0, "rand_fetch_ce0");
        end

        // Reset in the middle of a data word
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'd1);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'h66, 1'b0);
        do_reset();
        chk("midword_reset_ready",   32'(load_ready_o), 32'd1);
        chk("midword_reset_cpu_rst", 32'(cpu_rst_o),    32'd1);
        send_word(32'd1);
        send_word(32'h1122_3344);
        fetch(1'b1, 32'h0, 32'h1122_3344, "midword_reload_word0");

        // Oversize header
        do_reset();
        send_word(32'h0000_0401);
        chk("oversize_err",     32'(load_err_o),   32'd1);
        chk("oversize_cpu_rst", 32'(cpu_rst_o),    32'd1);
        chk("oversize_ready",   32'(load_ready_o), 32'd0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        fetch(1'b1, 32'h0, 32'h1122_3344, "err_fetch_served");

        // Largest legal length is accepted
        do_reset();
        send_word(32'h0000_0400);
        chk("maxlen_err",   32'(load_err_o),   32'd0);
        chk("maxlen_ready", 32'(load_ready_o), 32'd1);
        w = 32'hCAFE_0001;
        send_word(w);
        fetch(1'b1, 32'h0, w, "maxlen_word0");
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
